pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards between ID and EX, and branch-taken redirects from ID.
- Detects multi-cycle data-memory waits in MEM.
- Drives the freeze/flush/bubble controls of the PC register and of the IF2ID, ID2EX and EX2MEM pipeline registers.
- Small FSM handles multi-cycle load stalls and memory waits, with a timeout watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flush,
// memory-wait freeze with watchdog. Optional HAZARD_STATS_EN adds event counters.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 64,
  parameter int REG_ADDR_LEN      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_uses_src1,
  input  logic                    id_uses_src2,
  input  logic [REG_ADDR_LEN-1:0] ex_dest,
  input  logic                    ex_wb_en,
  input  logic                    ex_mem_read,
  input  logic                    branch_taken,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  output logic                    pc_freeze,
  output logic                    if2id_freeze,
  output logic                    if2id_flush,
  output logic                    id2ex_bubble,
  output logic                    id2ex_freeze,
  output logic                    ex2mem_freeze,
  output logic                    mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             lu_stall_count,
  output logic [31:0]             flush_count,
  output logic [31:0]             mem_wait_count
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

  localparam logic [3:0]  LU_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_W = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;
  logic        lu, mem_stall;

  assign lu = ex_mem_read & ex_wb_en & (ex_dest != '0) &
              ((id_uses_src1 & (id_src1 == ex_dest)) |
               (id_uses_src2 & (id_src2 == ex_dest)));
  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    timeout_d     = timeout_q;
    pc_freeze     = 1'b0;
    if2id_freeze  = 1'b0;
    if2id_flush   = 1'b0;
    id2ex_bubble  = 1'b0;
    id2ex_freeze  = 1'b0;
    ex2mem_freeze = 1'b0;
    mem_timeout   = timeout_q;
    if (rst) begin
      state_d     = RUN;
      cnt_d       = '0;
      timer_d     = '0;
      timeout_d   = 1'b0;
      mem_timeout = 1'b0;
    end else begin
      case (state_q)
        RUN, LU_STALL: begin
          if (mem_stall) begin
            // Entering the wait discards any remaining load-use count.
            pc_freeze     = 1'b1;
            if2id_freeze  = 1'b1;
            id2ex_freeze  = 1'b1;
            ex2mem_freeze = 1'b1;
            timer_d       = 16'd1;
            cnt_d         = '0;
            state_d       = MEM_WAIT;
          end else if (state_q == LU_STALL) begin
            pc_freeze    = 1'b1;
            if2id_freeze = 1'b1;
            id2ex_bubble = 1'b1;
            cnt_d        = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RUN;
          end else if (lu) begin
            pc_freeze    = 1'b1;
            if2id_freeze = 1'b1;
            id2ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_d   = LU_RELOAD;
              state_d = LU_STALL;
            end
          end else if (branch_taken) begin
            if2id_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            timer_d = '0;
            state_d = RUN;
          end else if (timer_q == TIMEOUT_W) begin
            timeout_d = 1'b1;
            timer_d   = '0;
            state_d   = RUN;
          end else begin
            pc_freeze     = 1'b1;
            if2id_freeze  = 1'b1;
            id2ex_freeze  = 1'b1;
            ex2mem_freeze = 1'b1;
            timer_d       = timer_q + 16'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_count <= '0;
      flush_count    <= '0;
      mem_wait_count <= '0;
    end else begin
      if (id2ex_bubble && lu_stall_count != '1) lu_stall_count <= lu_stall_count + 32'd1;
      if (if2id_flush && flush_count != '1)     flush_count    <= flush_count + 32'd1;
      if (ex2mem_freeze && mem_wait_count != '1) mem_wait_count <= mem_wait_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl; two instances (3-bubble/8-cycle
// watchdog and 1-bubble/64-cycle watchdog) share stimulus and are checked against a model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, us1, us2, wb, mr, br, rq, rd;
  logic [4:0] s1, s2, dst;
  logic [6:0] o3, o1;
  logic       pc3, ff3, fl3, bb3, idf3, exf3, to3;
  logic       pc1, ff1, fl1, bb1, idf1, exf1, to1;
`ifdef HAZARD_STATS_EN
  logic [31:0] lc3, fc3, mc3, lc1, fc1, mc1;
`endif

  assign o3 = {pc3, ff3, fl3, bb3, idf3, exf3, to3};
  assign o1 = {pc1, ff1, fl1, bb1, idf1, exf1, to1};

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8), .REG_ADDR_LEN(5)) u3 (
    .clk(clk), .rst(rst), .id_src1(s1), .id_src2(s2), .id_uses_src1(us1), .id_uses_src2(us2),
    .ex_dest(dst), .ex_wb_en(wb), .ex_mem_read(mr), .branch_taken(br), .mem_req(rq),
    .mem_ready(rd), .pc_freeze(pc3), .if2id_freeze(ff3), .if2id_flush(fl3),
    .id2ex_bubble(bb3), .id2ex_freeze(idf3), .ex2mem_freeze(exf3), .mem_timeout(to3)
`ifdef HAZARD_STATS_EN
    , .lu_stall_count(lc3), .flush_count(fc3), .mem_wait_count(mc3)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(64), .REG_ADDR_LEN(5)) u1 (
    .clk(clk), .rst(rst), .id_src1(s1), .id_src2(s2), .id_uses_src1(us1), .id_uses_src2(us2),
    .ex_dest(dst), .ex_wb_en(wb), .ex_mem_read(mr), .branch_taken(br), .mem_req(rq),
    .mem_ready(rd), .pc_freeze(pc1), .if2id_freeze(ff1), .if2id_flush(fl1),
    .id2ex_bubble(bb1), .id2ex_freeze(idf1), .ex2mem_freeze(exf1), .mem_timeout(to1)
`ifdef HAZARD_STATS_EN
    , .lu_stall_count(lc1), .flush_count(fc1), .mem_wait_count(mc1)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: per instance, bubbles still owed, cycles spent waiting, sticky timeout.
  int   lsc [2] = '{3, 1};
  int   tmo [2] = '{8, 64};
  int   owed [2];
  int   waited [2];
  bit   in_wait [2];
  bit   tflag [2];
  logic [6:0] ex [2];
  longint st_exp [2][3];
  longint st_now [2][3];

  task automatic model_eval();
    bit hz;
    hz = mr & wb & (dst != 0) & ((us1 & (s1 == dst)) | (us2 & (s2 == dst)));
    for (int k = 0; k < 2; k++) begin
      logic [6:0] e;
      e = '0;
      st_exp[k] = st_now[k];
      if (rst) begin
        in_wait[k] = 0; owed[k] = 0; waited[k] = 0; tflag[k] = 0;
        st_now[k] = '{0, 0, 0};
      end else begin
        e[0] = tflag[k];
        if (in_wait[k]) begin
          if (rd) in_wait[k] = 0;
          else if (waited[k] >= tmo[k]) begin in_wait[k] = 0; tflag[k] = 1; end
          else begin e[6] = 1; e[5] = 1; e[2] = 1; e[1] = 1; waited[k]++; end
        end else if (rq && !rd) begin
          e[6] = 1; e[5] = 1; e[2] = 1; e[1] = 1;
          in_wait[k] = 1; waited[k] = 1; owed[k] = 0;
        end else if (owed[k] > 0) begin
          e[6] = 1; e[5] = 1; e[3] = 1; owed[k]--;
        end else if (hz) begin
          e[6] = 1; e[5] = 1; e[3] = 1; owed[k] = lsc[k] - 1;
        end else if (br) begin
          e[4] = 1;
        end
        st_now[k][0] += e[3];
        st_now[k][1] += e[4];
        st_now[k][2] += e[1];
      end
      ex[k] = e;
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a1, a2, input logic u_1, u_2,
                       input logic [4:0] d, input logic w, m, b, q, y);
    @(negedge clk);
    rst = r; s1 = a1; s2 = a2; us1 = u_1; us2 = u_2; dst = d;
    wb = w; mr = m; br = b; rq = q; rd = y;
    #1;
    cyc++;
    model_eval();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 0);
      total++;
      if (o3 !== 7'b0 || o1 !== 7'b0) begin
        bad++;
        $display("FAIL reset cyc%0d u3=%b u1=%b want 0000000", cyc, o3, o1);
      end
    end
  endtask

  task automatic test_load_use();
    int nb3 = 0, nb1 = 0;
    drive(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1);
    total++;
    if (o3 !== ex[0] || o1 !== ex[1]) begin
      bad++;
      $display("FAIL load_use cyc%0d u3=%b want=%b u1=%b want=%b", cyc, o3, ex[0], o1, ex[1]);
    end
    nb3 += int'(bb3); nb1 += int'(bb1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0, 1);
      total++;
      if (o3 !== ex[0] || o1 !== ex[1]) begin
        bad++;
        $display("FAIL load_use_tail cyc%0d u3=%b want=%b u1=%b want=%b", cyc, o3, ex[0], o1, ex[1]);
      end
      if (i < 2) begin
        total++;
        if (fl3 !== 1'b0) begin
          bad++;
          $display("FAIL branch_during_stall cyc%0d flush=%b want 0", cyc, fl3);
        end
      end
      nb3 += int'(bb3); nb1 += int'(bb1);
    end
    total++;
    if (nb3 != 3 || nb1 != 1) begin
      bad++;
      $display("FAIL bubble_count u3=%0d want 3 u1=%0d want 1", nb3, nb1);
    end
  endtask

  task automatic test_no_hazard();
    drive(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 1);
    total++;
    if (o3 !== 7'b0 || o1 !== 7'b0) begin
      bad++;
      $display("FAIL dest_zero cyc%0d u3=%b u1=%b want 0000000", cyc, o3, o1);
    end
    drive(0, 5'd1, 5'd7, 1, 0, 5'd7, 1, 1, 0, 0, 1);
    total++;
    if (o3 !== 7'b0 || o1 !== 7'b0) begin
      bad++;
      $display("FAIL src2_unused cyc%0d u3=%b u1=%b want 0000000", cyc, o3, o1);
    end
    drive(0, 5'd7, 5'd1, 0, 1, 5'd7, 0, 1, 0, 0, 1);
    total++;
    if (o3 !== 7'b0 || o1 !== 7'b0) begin
      bad++;
      $display("FAIL no_wb cyc%0d u3=%b u1=%b want 0000000", cyc, o3, o1);
    end
  endtask

  task automatic test_branch();
    drive(0, 5'd2, 5'd3, 1, 1, 5'd4, 1, 1, 1, 0, 1);
    total++;
    if (o3 !== 7'b0010000 || o1 !== 7'b0010000) begin
      bad++;
      $display("FAIL branch cyc%0d u3=%b u1=%b want 0010000", cyc, o3, o1);
    end
    drive(0, 5'd2, 5'd3, 1, 1, 5'd4, 1, 1, 0, 0, 1);
    total++;
    if (o3 !== 7'b0 || o1 !== 7'b0) begin
      bad++;
      $display("FAIL branch_end cyc%0d u3=%b u1=%b want 0000000", cyc, o3, o1);
    end
  endtask

  task automatic test_mem_wait();
    int nf3 = 0, nf1 = 0;
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, (i == 4));
      total++;
      if (o3 !== ex[0] || o1 !== ex[1]) begin
        bad++;
        $display("FAIL mem_wait cyc%0d u3=%b want=%b u1=%b want=%b", cyc, o3, ex[0], o1, ex[1]);
      end
      nf3 += int'(exf3 & pc3 & ff3 & idf3); nf1 += int'(exf1 & pc1 & ff1 & idf1);
    end
    total++;
    if (nf3 != 4 || nf1 != 4 || o3 !== 7'b0 || o1 !== 7'b0) begin
      bad++;
      $display("FAIL mem_wait_len u3=%0d u1=%0d want 4, release u3=%b u1=%b", nf3, nf1, o3, o1);
    end
  endtask

  task automatic test_timeout();
    int nf3 = 0;
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
      total++;
      if (o3 !== ex[0] || o1 !== ex[1]) begin
        bad++;
        $display("FAIL timeout_wait cyc%0d u3=%b want=%b u1=%b want=%b", cyc, o3, ex[0], o1, ex[1]);
      end
      nf3 += int'(exf3);
    end
    total++;
    if (nf3 != 8 || exf3 !== 1'b0) begin
      bad++;
      $display("FAIL timeout_len freeze_cycles=%0d want 8 last=%b want 0", nf3, exf3);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
      total++;
      if (to3 !== 1'b1 || exf1 !== 1'b1 || to1 !== 1'b0) begin
        bad++;
        $display("FAIL timeout_sticky cyc%0d to3=%b want 1 exf1=%b want 1 to1=%b want 0", cyc, to3, exf1, to1);
      end
    end
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
    total++;
    if (o3 !== 7'b0 || o1 !== 7'b0) begin
      bad++;
      $display("FAIL rst_mid_wait cyc%0d u3=%b u1=%b want 0000000", cyc, o3, o1);
    end
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    total++;
    if (o3 !== 7'b0 || o1 !== 7'b0) begin
      bad++;
      $display("FAIL after_rst cyc%0d u3=%b u1=%b want 0000000", cyc, o3, o1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      total++;
      if (o3 !== ex[0] || o1 !== ex[1]) begin
        bad++;
        $display("FAIL random cyc%0d u3=%b want=%b u1=%b want=%b", cyc, o3, ex[0], o1, ex[1]);
      end
`ifdef HAZARD_STATS_EN
      total++;
      if (!rst && (longint'(lc3) != st_exp[0][0] || longint'(fc3) != st_exp[0][1] ||
                   longint'(mc3) != st_exp[0][2] || longint'(lc1) != st_exp[1][0] ||
                   longint'(fc1) != st_exp[1][1] || longint'(mc1) != st_exp[1][2])) begin
        bad++;
        $display("FAIL stats cyc%0d u3=%0d/%0d/%0d want %0d/%0d/%0d u1=%0d/%0d/%0d want %0d/%0d/%0d",
                 cyc, lc3, fc3, mc3, st_exp[0][0], st_exp[0][1], st_exp[0][2],
                 lc1, fc1, mc1, st_exp[1][0], st_exp[1][1], st_exp[1][2]);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; s1 = '0; s2 = '0; us1 = 1'b0; us2 = 1'b0; dst = '0;
    wb = 1'b0; mr = 1'b0; br = 1'b0; rq = 1'b0; rd = 1'b1;
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0; waited[k] = 0; in_wait[k] = 0; tflag[k] = 0;
      st_now[k] = '{0, 0, 0}; st_exp[k] = '{0, 0, 0};
    end
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
